// File: rtl/ifmap_frame_loader_if.sv
// Bundle of host stream, accelerator DRAM read port and result handshake for ifmap_frame_loader.
// master = host/accelerator side, slave = loader.
interface ifmap_frame_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              DRAM_read_en;
  logic [ADDR_W-1:0] DRAM_read_addr;
  logic [7:0]        DRAM_data_in;
  logic              system_enable;
  logic [3:0]        final_out;
  logic              final_out_valid;
  logic [3:0]        result_data;
  logic              result_timeout;
  logic              result_valid;
  logic              result_ready;
  logic [15:0]       frame_count;

  modport master (
    output s_data, s_valid, DRAM_read_en, DRAM_read_addr, final_out, final_out_valid, result_ready,
    input  s_ready, DRAM_data_in, system_enable, result_data, result_timeout, result_valid, frame_count
  );

  modport slave (
    input  s_data, s_valid, DRAM_read_en, DRAM_read_addr, final_out, final_out_valid, result_ready,
    output s_ready, DRAM_data_in, system_enable, result_data, result_timeout, result_valid, frame_count
  );
endinterface

// File: rtl/ifmap_frame_loader.sv
// Loads one ifmap frame from the host, serves it to the accelerator while system_enable is high,
// then returns the class result (or a watchdog timeout) to the host.
module ifmap_frame_loader #(
  parameter int FRAME_BYTES    = 784,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic                clock,
  input logic                reset,
  ifmap_frame_loader_if.slave bus
);

  typedef enum logic [1:0] {LOAD, RUN, REPORT} state_t;

  localparam int                WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [WD_W-1:0]   watchdog;
  logic              s_ready_q;
  logic              system_enable_q;
  logic              result_valid_q;
  logic              result_timeout_q;
  logic [3:0]        result_data_q;
  logic [15:0]       frame_count_q;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem [FRAME_BYTES];
  logic              wr_fire;
  logic              rd_in_range;

  assign wr_fire     = (state == LOAD) && bus.s_valid;
  assign rd_in_range = 32'(bus.DRAM_read_addr) < 32'(FRAME_BYTES);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= LOAD;
      wr_ptr           <= '0;
      watchdog         <= '0;
      s_ready_q        <= 1'b1;
      system_enable_q  <= 1'b0;
      result_valid_q   <= 1'b0;
      result_timeout_q <= 1'b0;
      result_data_q    <= '0;
      frame_count_q    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.s_valid) begin
            if (wr_ptr == LAST_ADDR) begin
              wr_ptr          <= '0;
              watchdog        <= '0;
              s_ready_q       <= 1'b0;
              system_enable_q <= 1'b1;
              state           <= RUN;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end

        RUN: begin
          watchdog <= watchdog + 1'b1;
          // A result arriving on the last watchdog cycle still counts as a real result.
          if (bus.final_out_valid) begin
            result_data_q    <= bus.final_out;
            result_timeout_q <= 1'b0;
            system_enable_q  <= 1'b0;
            result_valid_q   <= 1'b1;
            state            <= REPORT;
          end else if (watchdog == WD_LAST) begin
            result_data_q    <= '0;
            result_timeout_q <= 1'b1;
            system_enable_q  <= 1'b0;
            result_valid_q   <= 1'b1;
            state            <= REPORT;
          end
        end

        REPORT: begin
          if (bus.result_ready) begin
            frame_count_q  <= frame_count_q + 1'b1;
            result_valid_q <= 1'b0;
            s_ready_q      <= 1'b1;
            state          <= LOAD;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

  // NOTE: the frame buffer has no reset so it maps onto block RAM; stale contents are harmless.
  always_ff @(posedge clock) begin
    if (!reset && wr_fire) begin
      mem[wr_ptr] <= bus.s_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (bus.DRAM_read_en) begin
      rd_data_q <= rd_in_range ? mem[bus.DRAM_read_addr] : 8'h00;
    end
  end

  assign bus.s_ready        = s_ready_q;
  assign bus.system_enable  = system_enable_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_timeout = result_timeout_q;
  assign bus.result_data    = result_data_q;
  assign bus.frame_count    = frame_count_q;
  assign bus.DRAM_data_in   = rd_data_q;

endmodule

// File: tb/tb_ifmap_frame_loader.sv
// Directed + randomized bench for ifmap_frame_loader with a byte-array model of the frame buffer.
module tb_ifmap_frame_loader;

  localparam int FRAME   = 784;
  localparam int TIMEOUT = 100;

  logic clock = 1'b0;
  logic reset;

  ifmap_frame_loader_if #(.ADDR_W(10)) bus ();

  ifmap_frame_loader #(
    .FRAME_BYTES   (FRAME),
    .ADDR_W        (10),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] model_mem [FRAME];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input int addr);
    logic [7:0] exp;
    exp = (addr < FRAME) ? model_mem[addr] : 8'h00;
    bus.DRAM_read_en   = 1'b1;
    bus.DRAM_read_addr = 10'(addr);
    step();
    bus.DRAM_read_en   = 1'b0;
    bus.DRAM_read_addr = 10'($urandom);
    check(tag, 32'(bus.DRAM_data_in), 32'(exp));
  endtask

  task automatic load_frame(input int n, input bit rnd, input bit bubbles);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          bus.s_valid         = 1'b0;
          bus.s_data          = 8'($urandom);
          bus.final_out_valid = 1'($urandom_range(0, 1));
          bus.final_out       = 4'($urandom);
          step();
        end
      end
      bus.final_out_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b0;
      d = rnd ? 8'($urandom) : 8'(i);
      model_mem[i] = d;
      bus.s_valid  = 1'b1;
      bus.s_data   = d;
      if (i == FRAME - 1) begin
        check("se_before_last", 32'(bus.system_enable), 32'd0);
        check("s_ready_before_last", 32'(bus.s_ready), 32'd1);
      end
      step();
    end
    bus.s_valid         = 1'b0;
    bus.final_out_valid = 1'b0;
    if (n == FRAME) begin
      check("se_rise", 32'(bus.system_enable), 32'd1);
      check("s_ready_in_run", 32'(bus.s_ready), 32'd0);
    end
  endtask

  task automatic full_readback();
    for (int a = 0; a < FRAME; a++) read_check("readback", a);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: observed timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset               = 1'b1;
    bus.s_data          = '0;
    bus.s_valid         = 1'b0;
    bus.DRAM_read_en    = 1'b0;
    bus.DRAM_read_addr  = '0;
    bus.final_out       = '0;
    bus.final_out_valid = 1'b0;
    bus.result_ready    = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_se", 32'(bus.system_enable), 32'd0);
    check("rst_rv", 32'(bus.result_valid), 32'd0);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    check("rst_dram", 32'(bus.DRAM_data_in), 32'd0);
    check("rst_timeout", 32'(bus.result_timeout), 32'd0);
    check("rst_result", 32'(bus.result_data), 32'd0);

    // Frame 1: i mod 256, no bubbles; ignored s_valid in RUN; result handshake with stall
    load_frame(FRAME, 1'b0, 1'b0);
    repeat (3) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
      step();
    end
    bus.s_valid = 1'b0;
    check("run_s_ready", 32'(bus.s_ready), 32'd0);
    check("run_se_held", 32'(bus.system_enable), 32'd1);
    read_check("rd_addr0", 0);
    read_check("rd_addr255", 255);
    read_check("rd_addr256", 256);
    read_check("rd_addr783", 783);
    step();
    check("rd_hold", 32'(bus.DRAM_data_in), 32'h0F);
    read_check("rd_addr800", 800);
    bus.final_out       = 4'd7;
    bus.final_out_valid = 1'b1;
    step();
    bus.final_out_valid = 1'b0;
    check("res_se_fall", 32'(bus.system_enable), 32'd0);
    check("res_rv_rise", 32'(bus.result_valid), 32'd1);
    repeat (5) begin
      bus.final_out       = 4'd2;
      bus.final_out_valid = 1'($urandom_range(0, 1));
      step();
    end
    bus.final_out_valid = 1'b0;
    check("res_rv_held", 32'(bus.result_valid), 32'd1);
    check("res_data7", 32'(bus.result_data), 32'd7);
    check("res_timeout0", 32'(bus.result_timeout), 32'd0);
    check("res_count_still0", 32'(bus.frame_count), 32'd0);
    full_readback();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    check("hs_frame_count1", 32'(bus.frame_count), 32'd1);
    check("hs_s_ready", 32'(bus.s_ready), 32'd1);
    check("hs_rv_fall", 32'(bus.result_valid), 32'd0);

    // Frame 2: random data with bubbles and stray final_out_valid; stray s_valid in RUN; timeout
    load_frame(FRAME, 1'b1, 1'b1);
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data  = 8'($urandom);
      step();
    end
    bus.s_valid = 1'b0;
    check("to_se_at_99", 32'(bus.system_enable), 32'd1);
    check("to_rv_at_99", 32'(bus.result_valid), 32'd0);
    step();
    check("to_rv", 32'(bus.result_valid), 32'd1);
    check("to_flag", 32'(bus.result_timeout), 32'd1);
    check("to_data0", 32'(bus.result_data), 32'd0);
    check("to_se_fall", 32'(bus.system_enable), 32'd0);
    full_readback();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    check("to_frame_count2", 32'(bus.frame_count), 32'd2);
    check("to_s_ready", 32'(bus.s_ready), 32'd1);

    // Frame 3: result on the final watchdog cycle wins over the timeout
    load_frame(FRAME, 1'b1, 1'b0);
    repeat (TIMEOUT - 1) step();
    check("sim_se_at_99", 32'(bus.system_enable), 32'd1);
    bus.final_out       = 4'd3;
    bus.final_out_valid = 1'b1;
    step();
    bus.final_out_valid = 1'b0;
    check("sim_rv", 32'(bus.result_valid), 32'd1);
    check("sim_data3", 32'(bus.result_data), 32'd3);
    check("sim_timeout0", 32'(bus.result_timeout), 32'd0);
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    check("sim_frame_count3", 32'(bus.frame_count), 32'd3);

    // Frame 4: reset after 400 bytes, then a full fresh frame
    load_frame(400, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_count", 32'(bus.frame_count), 32'd0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("mid_rst_se", 32'(bus.system_enable), 32'd0);
    check("mid_rst_dram", 32'(bus.DRAM_data_in), 32'd0);
    load_frame(FRAME, 1'b1, 1'b1);
    bus.final_out       = 4'd9;
    bus.final_out_valid = 1'b1;
    step();
    bus.final_out_valid = 1'b0;
    check("mid_res_data9", 32'(bus.result_data), 32'd9);
    full_readback();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    check("mid_frame_count1", 32'(bus.frame_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
